pcie_fifo_burst_reader: RTL and testbench

Drains the 128-bit read side of the audio-to-PCIe asynchronous FIFO and turns the buffered samples into fixed-length DMA write bursts toward the PCIe DMA engine. It runs entirely in the FIFO read clock domain. It waits until the FIFO read water level covers one full burst, then issues a request and streams exactly BURST_BEATS beats. Each burst is written at the next slot of a host ring buffer.

---
 rtl/pcie_dma_pkg.sv | 19 +
 rtl/pcie_rd_skid.sv | 53 +++++
 rtl/pcie_fifo_burst_reader.sv | 138 +++++++++++++
 tb/tb_pcie_fifo_burst_reader.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_dma_pkg.sv
// Shared state encoding, beat geometry and request-length helper for the
// PCIe-side DMA readers.
package pcie_dma_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2
    } state_e;

    localparam int BEAT_BYTES = 16;
    localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);

    // The DMA engine expects burst lengths as beats minus one.
    function automatic logic [7:0] encodeReqLen(input int beats);
        return 8'(beats - 1);
    endfunction

endpackage

// File: rtl/pcie_rd_skid.sv
// Two-entry registered buffer between a fixed-latency read port and a
// valid/ready consumer; the head stays stable until it is popped.
module pcie_rd_skid #(
    parameter int WIDTH = 128
)(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] pushData_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] head_o,
    output logic [1:0]       entries_o
);

    logic [WIDTH-1:0] slot_q [2];
    logic             wrPtr_q;
    logic             rdPtr_q;
    logic [1:0]       count_q;
    logic             popOk;
    logic             pushOk;

    assign popOk  = pop_i && (count_q != 2'd0);
    assign pushOk = push_i && ((count_q != 2'd2) || popOk);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wrPtr_q <= 1'b0;
            rdPtr_q <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (pushOk) begin
                wrPtr_q <= ~wrPtr_q;
            end
            if (popOk) begin
                rdPtr_q <= ~rdPtr_q;
            end
            count_q <= count_q + {1'b0, pushOk} - {1'b0, popOk};
        end
    end

    // Payload slots carry no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (pushOk) begin
            slot_q[wrPtr_q] <= pushData_i;
        end
    end

    assign valid_o   = (count_q != 2'd0);
    assign head_o    = slot_q[rdPtr_q];
    assign entries_o = count_q;

endmodule

// File: rtl/pcie_fifo_burst_reader.sv
// Drains the audio-to-PCIe FIFO read side into fixed-length DMA write bursts
// placed at successive slots of a host ring buffer.
module pcie_fifo_burst_reader
    import pcie_dma_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 128,
    parameter int                    LEVEL_WIDTH = 14,
    parameter int                    BURST_BEATS = 16,
    parameter int                    ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    RING_BEATS  = 4096
)(
    input  logic                   rd_clk,
    input  logic                   rd_rst,
    input  logic                   enable,
    output logic                   fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
    input  logic                   fifo_rd_empty,
    input  logic [LEVEL_WIDTH-1:0] fifo_rd_water_level,
    output logic                   req_valid,
    input  logic                   req_ready,
    output logic [ADDR_WIDTH-1:0]  req_addr,
    output logic [7:0]             req_len,
    output logic                   dat_valid,
    input  logic                   dat_ready,
    output logic [DATA_WIDTH-1:0]  dat_data,
    output logic                   dat_last,
    output logic [15:0]            burst_count
);

    localparam int CNT_W = $clog2(BURST_BEATS) + 1;
    localparam int PTR_W = $clog2(RING_BEATS);
    localparam logic [CNT_W-1:0]       FULL_CNT   = CNT_W'(BURST_BEATS);
    localparam logic [CNT_W-1:0]       LAST_IDX   = CNT_W'(BURST_BEATS - 1);
    localparam logic [PTR_W-1:0]       PTR_STEP   = PTR_W'(BURST_BEATS);
    localparam logic [LEVEL_WIDTH-1:0] LEVEL_NEED = LEVEL_WIDTH'(BURST_BEATS);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] fetchCnt_q, fetchCnt_d;
    logic [CNT_W-1:0] beatCnt_q, beatCnt_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [15:0]      burstCount_q, burstCount_d;
    logic             inflight_q;

    logic             bufValid;
    logic [1:0]       entries;
    logic [2:0]       credit;
    logic             pop;
    logic             rdEn;
    logic             lastFire;

    pcie_rd_skid #(
        .WIDTH(DATA_WIDTH)
    ) u_skid (
        .clk_i      (rd_clk),
        .rst_i      (rd_rst),
        .push_i     (inflight_q),
        .pushData_i (fifo_rd_data),
        .pop_i      (pop),
        .valid_o    (bufValid),
        .head_o     (dat_data),
        .entries_o  (entries)
    );

    assign pop      = bufValid && dat_ready;
    assign dat_valid = bufValid;
    assign dat_last = bufValid && (beatCnt_q == LAST_IDX);
    assign lastFire = pop && dat_last;

    // A read is allowed only if its word still finds room once it lands a cycle later.
    assign credit = {1'b0, entries} + {2'b00, inflight_q};
    assign rdEn   = (state_q == DATA) && (fetchCnt_q < FULL_CNT) && !fifo_rd_empty
                    && (credit <= 3'd1 + {2'b00, pop});

    assign fifo_rd_en  = rdEn;
    assign req_valid   = (state_q == REQ);
    assign req_addr    = BASE_ADDR + (ADDR_WIDTH'(ptr_q) << BEAT_SHIFT);
    assign req_len     = encodeReqLen(BURST_BEATS);
    assign burst_count = burstCount_q;

    always_comb begin
        state_d      = state_q;
        fetchCnt_d   = fetchCnt_q;
        beatCnt_d    = beatCnt_q;
        ptr_d        = ptr_q;
        burstCount_d = burstCount_q;
        case (state_q)
            IDLE: begin
                if (enable && (fifo_rd_water_level >= LEVEL_NEED)) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (req_ready) begin
                    state_d    = DATA;
                    fetchCnt_d = '0;
                    beatCnt_d  = '0;
                end
            end
            DATA: begin
                if (rdEn) begin
                    fetchCnt_d = fetchCnt_q + CNT_W'(1);
                end
                if (pop) begin
                    beatCnt_d = beatCnt_q + CNT_W'(1);
                end
                // Ring power-of-two size lets the pointer wrap by truncation.
                if (lastFire) begin
                    state_d      = IDLE;
                    ptr_d        = ptr_q + PTR_STEP;
                    burstCount_d = burstCount_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state_q      <= IDLE;
            fetchCnt_q   <= '0;
            beatCnt_q    <= '0;
            ptr_q        <= '0;
            burstCount_q <= '0;
            inflight_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetchCnt_q   <= fetchCnt_d;
            beatCnt_q    <= beatCnt_d;
            ptr_q        <= ptr_d;
            burstCount_q <= burstCount_d;
            inflight_q   <= rdEn;
        end
    end

endmodule

// File: tb/tb_pcie_fifo_burst_reader.sv
// Scoreboard bench for pcie_fifo_burst_reader with a behavioural FIFO model
// and a 64-beat ring so address wrap shows up within a few bursts.
module tb_pcie_fifo_burst_reader;

    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int          BEATS = 16;
    localparam int          RING  = 64;

    logic         rd_clk = 1'b0;
    logic         rd_rst = 1'b1;
    logic         enable = 1'b0;
    logic         fifo_rd_en;
    logic [127:0] fifo_rd_data = '0;
    logic         fifo_rd_empty = 1'b1;
    logic [13:0]  fifo_rd_water_level = '0;
    logic         req_valid;
    logic         req_ready = 1'b1;
    logic [31:0]  req_addr;
    logic [7:0]   req_len;
    logic         dat_valid;
    logic         dat_ready = 1'b1;
    logic [127:0] dat_data;
    logic         dat_last;
    logic [15:0]  burst_count;

    int checks = 0;
    int errors = 0;

    logic [127:0] fifoQ[$];
    logic [127:0] expQ[$];
    logic [31:0]  reqExpQ[$];
    logic [127:0] popWord;
    int levelForce = -1;
    int modelPtr   = 0;
    int wordSeq    = 0;
    int beatIdx    = 0;
    bit randomReady = 1'b0;

    int issued = 0;
    int pops   = 0;
    int maxOcc = 0;
    logic         prevStall   = 1'b0;
    logic         prevLast    = 1'b0;
    logic         prevReqFire = 1'b0;
    logic [127:0] prevData    = '0;

    pcie_fifo_burst_reader #(
        .DATA_WIDTH  (128),
        .LEVEL_WIDTH (14),
        .BURST_BEATS (BEATS),
        .ADDR_WIDTH  (32),
        .BASE_ADDR   (BASE),
        .RING_BEATS  (RING)
    ) dut (
        .rd_clk              (rd_clk),
        .rd_rst              (rd_rst),
        .enable              (enable),
        .fifo_rd_en          (fifo_rd_en),
        .fifo_rd_data        (fifo_rd_data),
        .fifo_rd_empty       (fifo_rd_empty),
        .fifo_rd_water_level (fifo_rd_water_level),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .req_addr            (req_addr),
        .req_len             (req_len),
        .dat_valid           (dat_valid),
        .dat_ready           (dat_ready),
        .dat_data            (dat_data),
        .dat_last            (dat_last),
        .burst_count         (burst_count)
    );

    always #5 rd_clk = ~rd_clk;

    task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    function automatic logic [127:0] makeWord(input int n);
        logic [31:0] v;
        v = 32'(n);
        return {v ^ 32'hCAFE_0000, ~v, v * 32'd3, v};
    endfunction

    // Loads whole bursts into the FIFO and records the expected request and beats.
    task automatic applyStimulus(input int nBursts);
        for (int b = 0; b < nBursts; b++) begin
            reqExpQ.push_back(BASE + 32'(modelPtr * 16));
            modelPtr = (modelPtr + BEATS) % RING;
            for (int i = 0; i < BEATS; i++) begin
                fifoQ.push_back(makeWord(wordSeq));
                expQ.push_back(makeWord(wordSeq));
                wordSeq++;
            end
        end
    endtask

    task automatic tick();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic waitBursts(input int target, input int budget);
        int n;
        n = 0;
        while (burst_count != 16'(target) && n < budget) begin
            @(negedge rd_clk);
            n++;
        end
        checkOutput("burst_count", burst_count, target);
    endtask

    // FIFO model: read data appears the cycle after fifo_rd_en; flags follow the queue.
    always @(posedge rd_clk) begin
        if (fifo_rd_en && fifoQ.size() > 0) begin
            popWord = fifoQ.pop_front();
            fifo_rd_data <= popWord;
        end
        #2;
        fifo_rd_empty = (fifoQ.size() == 0);
        fifo_rd_water_level = (levelForce >= 0) ? 14'(levelForce) : 14'(fifoQ.size());
    end

    always @(posedge rd_clk) begin
        #1;
        if (randomReady) begin
            dat_ready = 1'($urandom_range(0, 1));
        end
    end

    // Output monitor: pops the scoreboard on every handshake and checks hold behaviour.
    always @(negedge rd_clk) begin
        int occ;
        logic [127:0] w;
        logic [31:0]  a;
        if (rd_rst) begin
            prevStall   = 1'b0;
            prevReqFire = 1'b0;
            issued      = 0;
            pops        = 0;
        end else begin
            occ = issued - pops;
            if (occ > maxOcc) maxOcc = occ;
            if (prevStall) begin
                checkOutput("hold_valid", dat_valid, 1'b1);
                checkOutput("hold_data", dat_data, prevData);
                checkOutput("hold_last", dat_last, prevLast);
            end
            if (prevReqFire) checkOutput("rd_after_req", fifo_rd_en, 1'b1);
            if (req_valid) checkOutput("no_rd_in_req", fifo_rd_en, 1'b0);
            if (req_valid && req_ready) begin
                if (reqExpQ.size() == 0) begin
                    checkOutput("req_unexpected", 1'b1, 1'b0);
                end else begin
                    a = reqExpQ.pop_front();
                    checkOutput("req_addr", req_addr, a);
                    checkOutput("req_len", req_len, 8'd15);
                end
            end
            if (dat_valid && dat_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("beat_unexpected", 1'b1, 1'b0);
                end else begin
                    w = expQ.pop_front();
                    checkOutput("beat_data", dat_data, w);
                    checkOutput("beat_last", dat_last, beatIdx == BEATS - 1);
                end
                beatIdx = (beatIdx == BEATS - 1) ? 0 : beatIdx + 1;
                pops++;
            end
            if (fifo_rd_en) issued++;
            prevStall   = dat_valid && !dat_ready;
            prevData    = dat_data;
            prevLast    = dat_last;
            prevReqFire = req_valid && req_ready;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int seen;
        int n;

        repeat (3) @(posedge rd_clk);
        #1;
        rd_rst = 1'b0;
        @(negedge rd_clk);
        checkOutput("rst_rd_en", fifo_rd_en, 1'b0);
        checkOutput("rst_req_valid", req_valid, 1'b0);
        checkOutput("rst_dat_valid", dat_valid, 1'b0);
        checkOutput("rst_dat_last", dat_last, 1'b0);
        checkOutput("rst_burst_count", burst_count, 16'd0);
        checkOutput("rst_req_addr", req_addr, BASE);
        checkOutput("rst_req_len", req_len, 8'd15);

        // Single burst of words 0..15 with everything ready.
        tick();
        enable = 1'b1;
        applyStimulus(1);
        waitBursts(1, 200);

        // Water level one short of a burst must never start a request.
        tick();
        levelForce = 15;
        applyStimulus(1);
        seen = 0;
        repeat (20) begin
            @(negedge rd_clk);
            if (req_valid) seen++;
        end
        checkOutput("lvl15_no_req", seen, 0);
        tick();
        levelForce = 16;
        @(negedge rd_clk);
        checkOutput("lvl16_pre", req_valid, 1'b0);
        @(negedge rd_clk);
        checkOutput("lvl16_rise", req_valid, 1'b1);
        levelForce = -1;
        waitBursts(2, 200);

        // Request held off by the DMA engine.
        tick();
        req_ready = 1'b0;
        applyStimulus(1);
        n = 0;
        while (!req_valid && n < 50) begin
            @(negedge rd_clk);
            n++;
        end
        checkOutput("stall_req_seen", req_valid, 1'b1);
        repeat (10) begin
            @(negedge rd_clk);
            checkOutput("stall_valid", req_valid, 1'b1);
            checkOutput("stall_addr", req_addr, (reqExpQ.size() > 0) ? reqExpQ[0] : 32'hDEAD_BEEF);
            checkOutput("stall_rd_en", fifo_rd_en, 1'b0);
        end
        tick();
        req_ready = 1'b1;
        waitBursts(3, 200);

        // Eight bursts against a randomly stalling consumer; ring wraps on the way.
        tick();
        randomReady = 1'b1;
        applyStimulus(8);
        waitBursts(11, 3000);
        tick();
        randomReady = 1'b0;
        dat_ready = 1'b1;

        // Reset in the middle of a burst, then restart from the ring base.
        tick();
        applyStimulus(1);
        n = 0;
        while (beatIdx != 7 && n < 200) begin
            @(negedge rd_clk);
            #1;
            n++;
        end
        checkOutput("reach_beat7", beatIdx, 7);
        tick();
        rd_rst = 1'b1;
        fifoQ.delete();
        expQ.delete();
        reqExpQ.delete();
        modelPtr = 0;
        beatIdx  = 0;
        @(negedge rd_clk);
        checkOutput("mid_rst_rd_en", fifo_rd_en, 1'b0);
        checkOutput("mid_rst_req_valid", req_valid, 1'b0);
        checkOutput("mid_rst_dat_valid", dat_valid, 1'b0);
        checkOutput("mid_rst_dat_last", dat_last, 1'b0);
        checkOutput("mid_rst_burst_count", burst_count, 16'd0);
        checkOutput("mid_rst_req_addr", req_addr, BASE);
        tick();
        tick();
        rd_rst = 1'b0;
        tick();
        applyStimulus(1);
        waitBursts(1, 200);

        tick();
        checkOutput("sb_beats_left", expQ.size(), 0);
        checkOutput("sb_reqs_left", reqExpQ.size(), 0);
        checkOutput("skid_depth", maxOcc <= 2, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
